// File: rtl/exception_commit_seq_if.sv
// Connection bundle between the exception controller side and the commit sequencer.
// The master side raises requests and reports memory activity; the slave side
// (the sequencer) returns stall, flush, redirect and CP0 strobes.
interface exception_commit_seq_if;
  logic        exc_req;
  logic        exc_is_refetch;
  logic        exc_cp0_upd;
  logic [31:0] exc_target_pc;
  logic        mem_busy;
  logic        pipe_stall;
  logic        flush_pipeline;
  logic        pc_redirect_ena;
  logic [31:0] pc_redirect;
  logic        cp0_commit_ena;
  logic        drain_timeout;
  logic        busy;
  logic [15:0] flush_count;

  modport master (
    output exc_req, exc_is_refetch, exc_cp0_upd, exc_target_pc, mem_busy,
    input  pipe_stall, flush_pipeline, pc_redirect_ena, pc_redirect,
           cp0_commit_ena, drain_timeout, busy, flush_count
  );

  modport slave (
    input  exc_req, exc_is_refetch, exc_cp0_upd, exc_target_pc, mem_busy,
    output pipe_stall, flush_pipeline, pc_redirect_ena, pc_redirect,
           cp0_commit_ena, drain_timeout, busy, flush_count
  );
endinterface

// File: rtl/exception_commit_seq.sv
// Exception / refetch commit sequencer.
// Accepts a request in IDLE, waits for outstanding memory traffic to drain
// (bounded by DRAIN_TIMEOUT), emits a single aligned flush + redirect + CP0
// commit cycle, then stalls for COOLDOWN cycles before accepting again.
// Every output is either a register or a decode of registered state.
module exception_commit_seq #(
  parameter int DRAIN_TIMEOUT = 255,
  parameter int COOLDOWN      = 2,
  parameter int CNT_W         = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  exception_commit_seq_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2,
    ST_COOL  = 2'd3
  } state_t;

  // Terminal counts for the shared counter; the cooldown one is unused when COOLDOWN=0.
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] COOL_LAST  = CNT_W'((COOLDOWN > 0) ? (COOLDOWN - 1) : 0);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        pc_q, pc_d;
  logic               refetch_q, refetch_d;
  logic               cp0_upd_q, cp0_upd_d;
  logic               timeout_q, timeout_d;
  logic [15:0]        flush_cnt_q, flush_cnt_d;

  // State and datapath registers; reset drops straight back to IDLE with no pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      pc_q        <= 32'h0;
      refetch_q   <= 1'b0;
      cp0_upd_q   <= 1'b0;
      timeout_q   <= 1'b0;
      flush_cnt_q <= 16'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pc_q        <= pc_d;
      refetch_q   <= refetch_d;
      cp0_upd_q   <= cp0_upd_d;
      timeout_q   <= timeout_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Next-state logic; the request is only looked at in IDLE so a latched target is never overwritten.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_d        = pc_q;
    refetch_d   = refetch_q;
    cp0_upd_d   = cp0_upd_q;
    timeout_d   = 1'b0;
    flush_cnt_d = flush_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.exc_req) begin
          pc_d      = bus.exc_target_pc;
          refetch_d = bus.exc_is_refetch;
          cp0_upd_d = bus.exc_cp0_upd;
          cnt_d     = '0;
          state_d   = bus.mem_busy ? ST_DRAIN : ST_FLUSH;
        end
      end
      ST_DRAIN: begin
        cnt_d = cnt_q + 1'b1;
        if (!bus.mem_busy) begin
          // A drain that completes on the last allowed cycle still counts as normal.
          state_d = ST_FLUSH;
        end else if (cnt_q == DRAIN_LAST) begin
          state_d   = ST_FLUSH;
          timeout_d = 1'b1;
        end
      end
      ST_FLUSH: begin
        flush_cnt_d = flush_cnt_q + 16'd1;
        cnt_d       = '0;
        state_d     = (COOLDOWN == 0) ? ST_IDLE : ST_COOL;
      end
      ST_COOL: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == COOL_LAST) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from registered state only.
  assign bus.busy            = (state_q != ST_IDLE);
  assign bus.pipe_stall      = (state_q != ST_IDLE);
  assign bus.flush_pipeline  = (state_q == ST_FLUSH);
  assign bus.pc_redirect_ena = (state_q == ST_FLUSH);
  assign bus.cp0_commit_ena  = (state_q == ST_FLUSH) & cp0_upd_q & ~refetch_q;
  assign bus.drain_timeout   = (state_q == ST_FLUSH) & timeout_q;
  assign bus.pc_redirect     = pc_q;
  assign bus.flush_count     = flush_cnt_q;

endmodule

// File: tb/tb_exception_commit_seq.sv
// Bench for exception_commit_seq: three instances with different drain/cooldown
// settings share one stimulus stream and are each compared every cycle against
// a per-instance behavioural model, plus directed checks of the key scenarios.
module tb_exception_commit_seq;

  localparam int NI = 3;
  localparam int DT1 = 4;
  localparam int CD1 = 3;
  localparam int DT2 = 5;
  localparam int CD2 = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        rf  = 1'b0;
  logic        cp0 = 1'b0;
  logic [31:0] tpc = 32'h0;
  logic        mb  = 1'b0;

  logic [NI-1:0] o_stall, o_flush, o_ena, o_cp0, o_to, o_busy;
  logic [31:0]   o_pc [NI];
  logic [15:0]   o_fc [NI];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  exception_commit_seq_if bus_if [NI] ();

  genvar gi;
  generate
    for (gi = 0; gi < NI; gi++) begin : g_dut
      assign bus_if[gi].exc_req        = req;
      assign bus_if[gi].exc_is_refetch = rf;
      assign bus_if[gi].exc_cp0_upd    = cp0;
      assign bus_if[gi].exc_target_pc  = tpc;
      assign bus_if[gi].mem_busy       = mb;
      assign o_stall[gi] = bus_if[gi].pipe_stall;
      assign o_flush[gi] = bus_if[gi].flush_pipeline;
      assign o_ena[gi]   = bus_if[gi].pc_redirect_ena;
      assign o_cp0[gi]   = bus_if[gi].cp0_commit_ena;
      assign o_to[gi]    = bus_if[gi].drain_timeout;
      assign o_busy[gi]  = bus_if[gi].busy;
      assign o_pc[gi]    = bus_if[gi].pc_redirect;
      assign o_fc[gi]    = bus_if[gi].flush_count;
      if (gi == 0) begin : g_default
        exception_commit_seq u_dut (.clk(clk), .rst(rst), .bus(bus_if[gi]));
      end else begin : g_param
        exception_commit_seq #(
          .DRAIN_TIMEOUT((gi == 1) ? DT1 : DT2),
          .COOLDOWN     ((gi == 1) ? CD1 : CD2),
          .CNT_W        (8)
        ) u_dut (.clk(clk), .rst(rst), .bus(bus_if[gi]));
      end
    end
  endgenerate

  // Reference model: phase plus elapsed/remaining cycle counts per instance.
  typedef enum int {M_IDLE, M_DRAIN, M_FLUSH, M_COOL} mode_t;
  mode_t       m_mode   [NI];
  int          m_waited [NI];
  int          m_left   [NI];
  logic [31:0] m_pc     [NI];
  logic        m_commit [NI];
  logic        m_to     [NI];
  logic [15:0] m_fc     [NI];

  function automatic int dt_of(input int i);
    return (i == 0) ? 255 : (i == 1) ? DT1 : DT2;
  endfunction

  function automatic int cd_of(input int i);
    return (i == 0) ? 2 : (i == 1) ? CD1 : CD2;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int i);
    if (rst) begin
      m_mode[i] = M_IDLE; m_waited[i] = 0; m_left[i] = 0;
      m_pc[i] = 32'h0; m_commit[i] = 1'b0; m_to[i] = 1'b0; m_fc[i] = 16'h0;
      return;
    end
    case (m_mode[i])
      M_IDLE: if (req) begin
        m_pc[i]     = tpc;
        m_commit[i] = cp0 & ~rf;
        m_to[i]     = 1'b0;
        m_waited[i] = 0;
        m_mode[i]   = mb ? M_DRAIN : M_FLUSH;
      end
      M_DRAIN: begin
        m_waited[i]++;
        if (!mb) begin
          m_mode[i] = M_FLUSH; m_to[i] = 1'b0;
        end else if (m_waited[i] == dt_of(i)) begin
          m_mode[i] = M_FLUSH; m_to[i] = 1'b1;
        end
      end
      M_FLUSH: begin
        m_fc[i]++;
        m_to[i] = 1'b0;
        if (cd_of(i) == 0) m_mode[i] = M_IDLE;
        else begin
          m_mode[i] = M_COOL; m_left[i] = cd_of(i);
        end
      end
      M_COOL: begin
        m_left[i]--;
        if (m_left[i] == 0) m_mode[i] = M_IDLE;
      end
      default: m_mode[i] = M_IDLE;
    endcase
  endtask

  task automatic compare_all(input int i);
    logic fl;
    fl = (m_mode[i] == M_FLUSH);
    check_val($sformatf("u%0d.busy", i),  32'(o_busy[i]),  32'(m_mode[i] != M_IDLE));
    check_val($sformatf("u%0d.stall", i), 32'(o_stall[i]), 32'(m_mode[i] != M_IDLE));
    check_val($sformatf("u%0d.flush", i), 32'(o_flush[i]), 32'(fl));
    check_val($sformatf("u%0d.ena", i),   32'(o_ena[i]),   32'(fl));
    check_val($sformatf("u%0d.cp0", i),   32'(o_cp0[i]),   32'(fl & m_commit[i]));
    check_val($sformatf("u%0d.tmo", i),   32'(o_to[i]),    32'(fl & m_to[i]));
    check_val($sformatf("u%0d.pc", i),    o_pc[i],         m_pc[i]);
    check_val($sformatf("u%0d.fcnt", i),  32'(o_fc[i]),    32'(m_fc[i]));
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < NI; i++) model_step(i);
    #1;
    for (int i = 0; i < NI; i++) compare_all(i);
    if (m_mode[0] == M_FLUSH)
      $display("txn u0 flush #%0d pc=%h commit=%0b timeout=%0b",
               m_fc[0] + 16'd1, m_pc[0], m_commit[0], m_to[0]);
  endtask

  task automatic idle(input int n);
    req = 1'b0; mb = 1'b0;
    repeat (n) tick();
  endtask

  task automatic issue(input logic [31:0] pc, input logic is_rf, input logic upd, input logic busy_mem);
    req = 1'b1; tpc = pc; rf = is_rf; cp0 = upd; mb = busy_mem;
    tick();
    req = 1'b0;
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (2) tick();
    check_val("rst.busy", 32'(o_busy[0]), 32'd0);
    check_val("rst.pc",   o_pc[0],        32'h0);
    check_val("rst.fcnt", 32'(o_fc[0]),   32'd0);
    rst = 1'b0;
    idle(2);

    // Exception with memory idle: flush next cycle, COOLDOWN=2 stall
    issue(32'hbfc0_0380, 1'b0, 1'b1, 1'b0);
    check_val("t1.flush", 32'(o_flush[0]), 32'd1);
    check_val("t1.cp0",   32'(o_cp0[0]),   32'd1);
    check_val("t1.pc",    o_pc[0],         32'hbfc0_0380);
    tick();
    check_val("t1.busy_cool",  32'(o_busy[0]), 32'd1);
    check_val("t1.busy_cd0",   32'(o_busy[2]), 32'd0);
    tick();
    check_val("t1.busy_t3", 32'(o_busy[0]), 32'd1);
    tick();
    check_val("t1.idle_t4", 32'(o_busy[0]), 32'd0);
    idle(3);

    // Refetch: redirect without CP0 commit
    issue(32'h8000_1000, 1'b1, 1'b1, 1'b0);
    check_val("t2.flush", 32'(o_flush[0]), 32'd1);
    check_val("t2.cp0",   32'(o_cp0[0]),   32'd0);
    check_val("t2.pc",    o_pc[0],         32'h8000_1000);
    idle(5);

    // Five-cycle drain; instance 2 sees mem_busy drop exactly on its timeout cycle
    issue(32'h0000_4444, 1'b0, 1'b1, 1'b1);
    repeat (4) tick();
    mb = 1'b0;
    tick();
    check_val("t3.flush",    32'(o_flush[0]), 32'd1);
    check_val("t3.tmo",      32'(o_to[0]),    32'd0);
    check_val("t3.flush_u2", 32'(o_flush[2]), 32'd1);
    check_val("t3.tmo_u2",   32'(o_to[2]),    32'd0);
    idle(6);

    // Stuck mem_busy: instance 1 times out after 4 drain cycles
    issue(32'h0000_5555, 1'b0, 1'b0, 1'b1);
    repeat (3) tick();
    check_val("t4.noflush", 32'(o_flush[1]), 32'd0);
    tick();
    check_val("t4.flush",   32'(o_flush[1]), 32'd1);
    check_val("t4.tmo",     32'(o_to[1]),    32'd1);
    check_val("t4.u0drain", 32'(o_flush[0]), 32'd0);
    idle(8);

    // Request during COOL is ignored
    issue(32'hbfc0_0380, 1'b0, 1'b1, 1'b0);
    req = 1'b1; tpc = 32'hbfc0_0200;
    tick();
    tick();
    req = 1'b0;
    check_val("t5.pc",    o_pc[0],         32'hbfc0_0380);
    check_val("t5.flush", 32'(o_flush[0]), 32'd0);
    idle(6);

    // Reset while draining
    issue(32'h0000_6666, 1'b0, 1'b1, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    check_val("t6.busy",  32'(o_busy[0]),  32'd0);
    check_val("t6.flush", 32'(o_flush[0]), 32'd0);
    check_val("t6.cp0",   32'(o_cp0[0]),   32'd0);
    check_val("t6.fcnt",  32'(o_fc[0]),    32'd0);
    rst = 1'b0;
    idle(3);

    // Randomized traffic with sticky mem_busy runs to exercise both drain outcomes
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      req = ($urandom_range(0, 2) == 0);
      rf  = $urandom_range(0, 1) == 1;
      cp0 = $urandom_range(0, 1) == 1;
      tpc = $urandom;
      if ($urandom_range(0, 7) == 0) mb = ~mb;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
